core_req_arbiter: RTL and testbench

// Shares the afu_io TX_RD and TX_WR request ports between NUM_CORES SMEM pipeline cores.

---
 rtl/core_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_core_req_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_req_arbiter.sv
// core_req_arbiter: round-robin sharing of afu_io TX_RD / TX_WR
// between SMEM cores, with write-burst lock and read credit limit.
module core_req_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int MAX_RD_OUT = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CORES-1:0]     req_rd_valid,
   input  logic [NUM_CORES*58-1:0]  req_rd_addr,
   output logic [NUM_CORES-1:0]     req_rd_ready,
   input  logic [NUM_CORES-1:0]     req_wr_valid,
   input  logic [NUM_CORES-1:0]     req_wr_fence,
   input  logic [NUM_CORES*58-1:0]  req_wr_addr,
   input  logic [NUM_CORES*6-1:0]   req_wr_len,
   input  logic [NUM_CORES*512-1:0] req_wr_data,
   output logic [NUM_CORES-1:0]     req_wr_ready,
   input  logic                     spl_tx_rd_almostfull,
   input  logic                     spl_tx_wr_almostfull,
   input  logic                     io_rx_rd_valid,
   output logic                     cor_tx_rd_valid,
   output logic [57:0]              cor_tx_rd_addr,
   output logic [5:0]               cor_tx_rd_len,
   output logic                     cor_tx_wr_valid,
   output logic                     cor_tx_fence_valid,
   output logic [57:0]              cor_tx_wr_addr,
   output logic [5:0]               cor_tx_wr_len,
   output logic [511:0]             cor_tx_data,
   output logic [5:0]               rd_outstanding,
   output logic                     err_rd_underflow
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CW = $clog2(MAX_RD_OUT + 1);

   typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

   // first valid requester at or after ptr, circular
   function automatic logic [PW-1:0] rr_pick(
      input logic [NUM_CORES-1:0] v,
      input logic [PW-1:0]        ptr
   );
      logic [PW-1:0] w;
      int idx;
      w = ptr;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_CORES;
         if (v[idx]) w = PW'(idx);
      end
      return w;
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
      return (int'(w) == NUM_CORES - 1) ? '0 : PW'(int'(w) + 1);
   endfunction

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_win;
   logic [CW-1:0] rd_cnt;
   logic          rd_go;

   assign rd_win = rr_pick(req_rd_valid, rd_ptr);
   assign rd_go  = reset_n & (|req_rd_valid) & ~spl_tx_rd_almostfull
                 & (rd_cnt < CW'(MAX_RD_OUT));
   assign cor_tx_rd_len  = 6'h1;
   assign rd_outstanding = 6'(rd_cnt);

   // one-hot read accept for the round-robin winner
   always_comb begin
      req_rd_ready         = '0;
      req_rd_ready[rd_win] = rd_go;
   end

   // read request register, rr pointer and in-flight credit count
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cor_tx_rd_valid  <= 1'b0;
         cor_tx_rd_addr   <= '0;
         rd_ptr           <= '0;
         rd_cnt           <= '0;
         err_rd_underflow <= 1'b0;
      end else begin
         cor_tx_rd_valid <= rd_go;
         if (rd_go) begin
            cor_tx_rd_addr <= req_rd_addr[58*int'(rd_win) +: 58];
            rd_ptr         <= rr_next(rd_win);
         end
         if (rd_go && !io_rx_rd_valid)
            rd_cnt <= rd_cnt + CW'(1);
         else if (!rd_go && io_rx_rd_valid && rd_cnt != '0)
            rd_cnt <= rd_cnt - CW'(1);
         if (io_rx_rd_valid && rd_cnt == '0)
            err_rd_underflow <= 1'b1;
      end
   end

   wr_state_t     wr_state;
   wr_state_t     wr_state_nxt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_win;
   logic [PW-1:0] wr_owner;
   logic [PW-1:0] wr_sel;
   logic [57:0]   wr_base;
   logic [5:0]    wr_len;
   logic [5:0]    wr_beat;
   logic [5:0]    win_raw;
   logic [5:0]    win_len;
   logic          win_fence;
   logic          last_beat;
   logic          wr_go;
   logic [57:0]   beat_addr;

   assign wr_win    = rr_pick(req_wr_valid, wr_ptr);
   assign win_fence = req_wr_fence[wr_win];
   assign win_raw   = req_wr_len[6*int'(wr_win) +: 6];
   assign win_len   = (win_fence || win_raw == 6'd0) ? 6'd1 : win_raw;
   assign last_beat = (wr_beat + 6'd1) == wr_len;
   assign beat_addr = (wr_state == WR_IDLE)
                    ? req_wr_addr[58*int'(wr_sel) +: 58]
                    : wr_base + 58'(wr_beat);

   // burst lock: pick a new owner when idle, else serve only the owner
   always_comb begin
      wr_state_nxt = wr_state;
      wr_sel       = wr_win;
      wr_go        = 1'b0;
      unique case (wr_state)
         WR_IDLE: begin
            wr_go = reset_n & (|req_wr_valid) & ~spl_tx_wr_almostfull;
            if (wr_go && win_len != 6'd1) wr_state_nxt = WR_BURST;
         end
         WR_BURST: begin
            wr_sel = wr_owner;
            wr_go  = reset_n & req_wr_valid[wr_owner]
                   & ~req_wr_fence[wr_owner] & ~spl_tx_wr_almostfull;
            if (wr_go && last_beat) wr_state_nxt = WR_IDLE;
         end
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   // one-hot write beat accept
   always_comb begin
      req_wr_ready         = '0;
      req_wr_ready[wr_sel] = wr_go;
   end

   // write state register
   always_ff @(posedge clk) begin
      if (!reset_n) wr_state <= WR_IDLE;
      else          wr_state <= wr_state_nxt;
   end

   // write beat register, burst bookkeeping and rr pointer
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cor_tx_wr_valid    <= 1'b0;
         cor_tx_fence_valid <= 1'b0;
         cor_tx_wr_addr     <= '0;
         cor_tx_wr_len      <= '0;
         cor_tx_data        <= '0;
         wr_ptr             <= '0;
         wr_owner           <= '0;
         wr_base            <= '0;
         wr_len             <= '0;
         wr_beat            <= '0;
      end else begin
         cor_tx_wr_valid    <= wr_go;
         cor_tx_fence_valid <= wr_go & (wr_state == WR_IDLE) & win_fence;
         if (wr_go) begin
            cor_tx_wr_addr <= beat_addr;
            cor_tx_data    <= req_wr_data[512*int'(wr_sel) +: 512];
            if (wr_state == WR_IDLE) begin
               cor_tx_wr_len <= win_len;
               wr_owner      <= wr_win;
               wr_base       <= beat_addr;
               wr_len        <= win_len;
               wr_beat       <= 6'd1;
               if (win_len == 6'd1) wr_ptr <= rr_next(wr_win);
            end else begin
               wr_beat <= wr_beat + 6'd1;
               if (last_beat) wr_ptr <= rr_next(wr_owner);
            end
         end
      end
   end

endmodule

// File: tb/tb_core_req_arbiter.sv
// tb_core_req_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_core_req_arbiter;
   localparam int N    = 4;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [N-1:0]     req_rd_valid = '0;
   logic [N*58-1:0]  req_rd_addr = '0;
   logic [N-1:0]     req_rd_ready;
   logic [N-1:0]     req_wr_valid = '0;
   logic [N-1:0]     req_wr_fence = '0;
   logic [N*58-1:0]  req_wr_addr = '0;
   logic [N*6-1:0]   req_wr_len = '0;
   logic [N*512-1:0] req_wr_data = '0;
   logic [N-1:0]     req_wr_ready;
   logic spl_tx_rd_almostfull = 1'b0;
   logic spl_tx_wr_almostfull = 1'b0;
   logic io_rx_rd_valid = 1'b0;
   logic          cor_tx_rd_valid;
   logic [57:0]   cor_tx_rd_addr;
   logic [5:0]    cor_tx_rd_len;
   logic          cor_tx_wr_valid;
   logic          cor_tx_fence_valid;
   logic [57:0]   cor_tx_wr_addr;
   logic [5:0]    cor_tx_wr_len;
   logic [511:0]  cor_tx_data;
   logic [5:0]    rd_outstanding;
   logic          err_rd_underflow;

   core_req_arbiter #(.NUM_CORES(N), .MAX_RD_OUT(MAXO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_rd_valid(req_rd_valid), .req_rd_addr(req_rd_addr),
      .req_rd_ready(req_rd_ready),
      .req_wr_valid(req_wr_valid), .req_wr_fence(req_wr_fence),
      .req_wr_addr(req_wr_addr), .req_wr_len(req_wr_len),
      .req_wr_data(req_wr_data), .req_wr_ready(req_wr_ready),
      .spl_tx_rd_almostfull(spl_tx_rd_almostfull),
      .spl_tx_wr_almostfull(spl_tx_wr_almostfull),
      .io_rx_rd_valid(io_rx_rd_valid),
      .cor_tx_rd_valid(cor_tx_rd_valid), .cor_tx_rd_addr(cor_tx_rd_addr),
      .cor_tx_rd_len(cor_tx_rd_len),
      .cor_tx_wr_valid(cor_tx_wr_valid),
      .cor_tx_fence_valid(cor_tx_fence_valid),
      .cor_tx_wr_addr(cor_tx_wr_addr), .cor_tx_wr_len(cor_tx_wr_len),
      .cor_tx_data(cor_tx_data), .rd_outstanding(rd_outstanding),
      .err_rd_underflow(err_rd_underflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model state
   int m_rd_ptr = 0, m_cnt = 0, m_wr_ptr = 0;
   int m_owner = 0, m_len = 0, m_sent = 0;
   bit m_err = 0, m_busy = 0;
   logic [57:0]  m_base = '0;
   bit           e_rv = 0, e_wv = 0, e_fv = 0;
   logic [57:0]  e_ra = '0, e_wa = '0;
   logic [5:0]   e_wl = '0;
   logic [511:0] e_wd = '0;
   int g_rd = -1, g_wr = -1;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [57:0] rnd58();
      logic [57:0] r;
      r = {26'($urandom), 32'($urandom)};
      return r;
   endfunction

   // one clock: check readys before the edge, outputs after it
   task automatic step();
      int rg, wg, el;
      logic [N-1:0] er, ew;
      #1;
      rg = -1;
      wg = -1;
      if (reset_n) begin
         if (!spl_tx_rd_almostfull && m_cnt < MAXO)
            rg = pick(req_rd_valid, m_rd_ptr);
         if (!spl_tx_wr_almostfull) begin
            if (!m_busy)
               wg = pick(req_wr_valid, m_wr_ptr);
            else if (req_wr_valid[m_owner] && !req_wr_fence[m_owner])
               wg = m_owner;
         end
      end
      er = '0;
      ew = '0;
      if (rg >= 0) er[rg] = 1'b1;
      if (wg >= 0) ew[wg] = 1'b1;
      chk("rd_ready", 512'(req_rd_ready), 512'(er));
      chk("wr_ready", 512'(req_wr_ready), 512'(ew));
      g_rd = rg;
      g_wr = wg;
      @(posedge clk);
      if (!reset_n) begin
         m_rd_ptr = 0; m_cnt = 0; m_wr_ptr = 0; m_busy = 0;
         m_err = 0; m_owner = 0; m_len = 0; m_sent = 0; m_base = '0;
         e_rv = 0; e_ra = '0; e_wv = 0; e_fv = 0;
         e_wa = '0; e_wl = '0; e_wd = '0;
      end else begin
         e_rv = (rg >= 0);
         if (rg >= 0) begin
            e_ra = req_rd_addr[58*rg +: 58];
            m_rd_ptr = (rg + 1) % N;
         end
         if (io_rx_rd_valid && m_cnt == 0) m_err = 1;
         if (rg >= 0 && !io_rx_rd_valid) m_cnt++;
         else if (rg < 0 && io_rx_rd_valid && m_cnt > 0) m_cnt--;
         e_wv = (wg >= 0);
         e_fv = 0;
         if (wg >= 0) begin
            e_wd = req_wr_data[512*wg +: 512];
            if (!m_busy) begin
               el = int'(req_wr_len[6*wg +: 6]);
               if (el == 0 || req_wr_fence[wg]) el = 1;
               e_fv = req_wr_fence[wg];
               e_wa = req_wr_addr[58*wg +: 58];
               e_wl = 6'(el);
               if (el > 1) begin
                  m_busy = 1; m_owner = wg; m_len = el; m_sent = 1;
                  m_base = req_wr_addr[58*wg +: 58];
               end else begin
                  m_wr_ptr = (wg + 1) % N;
               end
            end else begin
               e_wa = m_base + 58'(m_sent);
               e_wl = 6'(m_len);
               m_sent++;
               if (m_sent == m_len) begin
                  m_busy = 0;
                  m_wr_ptr = (m_owner + 1) % N;
               end
            end
         end
      end
      #1;
      chk("rd_valid", 512'(cor_tx_rd_valid), 512'(e_rv));
      chk("rd_addr", 512'(cor_tx_rd_addr), 512'(e_ra));
      chk("rd_len", 512'(cor_tx_rd_len), 512'(6'h1));
      chk("rd_outstanding", 512'(rd_outstanding), 512'(m_cnt));
      chk("rd_underflow", 512'(err_rd_underflow), 512'(m_err));
      chk("wr_valid", 512'(cor_tx_wr_valid), 512'(e_wv));
      chk("fence_valid", 512'(cor_tx_fence_valid), 512'(e_fv));
      chk("wr_addr", 512'(cor_tx_wr_addr), 512'(e_wa));
      chk("wr_len", 512'(cor_tx_wr_len), 512'(e_wl));
      chk("wr_data", cor_tx_data, e_wd);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic set_wr(input int c, input bit v, input bit f,
                         input logic [57:0] a, input logic [5:0] l,
                         input logic [511:0] d);
      req_wr_valid[c] = v;
      req_wr_fence[c] = f;
      req_wr_addr[58*c +: 58] = a;
      req_wr_len[6*c +: 6] = l;
      req_wr_data[512*c +: 512] = d;
   endtask

   int wleft[N];
   int wtot[N];

   initial begin
      #1;
      reset_n = 1'b0;
      steps(2);
      reset_n = 1'b1;

      // read fairness: all cores request, credits recycled each cycle
      for (int c = 0; c < N; c++)
         req_rd_addr[58*c +: 58] = 58'h1000 + 58'(c * 16);
      req_rd_valid = 4'hF;
      step();
      io_rx_rd_valid = 1'b1;
      steps(7);
      req_rd_valid = '0;
      step();
      io_rx_rd_valid = 1'b0;

      // credit limit
      req_rd_valid = 4'b0001;
      steps(6);
      chk("credit_full", 512'(rd_outstanding), 512'(MAXO));
      io_rx_rd_valid = 1'b1;
      step();
      io_rx_rd_valid = 1'b0;
      steps(3);
      // simultaneous grant + response at count 3
      req_rd_valid = '0;
      io_rx_rd_valid = 1'b1;
      step();
      req_rd_valid = 4'b0001;
      step();
      chk("simul_cnt", 512'(rd_outstanding), 512'(3));
      req_rd_valid = '0;
      steps(3);
      step();
      chk("underflow_cnt", 512'(rd_outstanding), 512'(0));
      chk("underflow_err", 512'(err_rd_underflow), 512'(1));
      io_rx_rd_valid = 1'b0;

      // burst lock with gap and back-pressure
      set_wr(1, 1, 0, 58'h100, 6'd4, rnd512());
      set_wr(2, 1, 0, 58'h200, 6'd1, rnd512());
      steps(2);
      req_wr_valid[1] = 1'b0;
      steps(2);
      req_wr_valid[1] = 1'b1;
      step();
      spl_tx_wr_almostfull = 1'b1;
      steps(2);
      spl_tx_wr_almostfull = 1'b0;
      step();
      chk("burst_last", 512'(cor_tx_wr_addr), 512'(58'h103));
      req_wr_valid[1] = 1'b0;
      step();
      req_wr_valid[2] = 1'b0;
      step();

      // reset in the middle of a burst
      set_wr(1, 1, 0, 58'h400, 6'd4, rnd512());
      steps(2);
      set_wr(0, 1, 0, 58'h300, 6'd1, rnd512());
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      #1;
      chk("rst_core0_first", 512'(req_wr_ready), 512'(4'b0001));
      step();
      req_wr_valid = '0;
      set_wr(0, 1, 1, 58'h500, 6'd3, rnd512());
      step();
      req_wr_valid = '0;
      req_wr_fence = '0;
      step();

      // random traffic
      for (int c = 0; c < N; c++) begin
         wleft[c] = 0;
         wtot[c] = 0;
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < N; c++) begin
            bit f;
            int l;
            logic [57:0] a;
            if (!req_rd_valid[c] && $urandom_range(1, 0) == 1) begin
               req_rd_valid[c] = 1'b1;
               req_rd_addr[58*c +: 58] = rnd58();
            end
            if (wleft[c] == 0 && $urandom_range(2, 0) == 0) begin
               f = ($urandom_range(7, 0) == 0);
               l = f ? 1 : $urandom_range(5, 0);
               a = ($urandom_range(3, 0) == 0)
                 ? ('1 - 58'($urandom_range(2, 0))) : rnd58();
               set_wr(c, 1, f, a, 6'(l), rnd512());
               wtot[c] = (l == 0) ? 1 : l;
               wleft[c] = wtot[c];
            end
            if (wleft[c] > 0)
               req_wr_valid[c] = (wleft[c] == wtot[c])
                               || ($urandom_range(3, 0) != 0);
         end
         spl_tx_rd_almostfull = ($urandom_range(4, 0) == 0);
         spl_tx_wr_almostfull = ($urandom_range(3, 0) == 0);
         io_rx_rd_valid = ($urandom_range(2, 0) == 0);
         reset_n = (cyc != 2000);
         step();
         if (!reset_n) begin
            req_rd_valid = '0;
            req_wr_valid = '0;
            req_wr_fence = '0;
            for (int c = 0; c < N; c++) wleft[c] = 0;
         end else begin
            if (g_rd >= 0) req_rd_valid[g_rd] = 1'b0;
            if (g_wr >= 0) begin
               wleft[g_wr]--;
               req_wr_data[512*g_wr +: 512] = rnd512();
               if (wleft[g_wr] == 0) begin
                  req_wr_valid[g_wr] = 1'b0;
                  req_wr_fence[g_wr] = 1'b0;
               end
            end
         end
      end
      reset_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
